hd44780_bus_responder: RTL

//  Device-side end of the HD44780 4-bit LCD bus: samples lcd_rs/lcd_rw/lcd_en/lcd_data as driven by
//  the host LCD controller and assembles nibbles into bytes. Decodes the HD44780 command set and

---
 rtl/hd44780_bus_responder_pkg.sv | 89 ++++++++
 rtl/hd44780_bus_responder_ddram.sv | 34 +++
 rtl/hd44780_bus_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_bus_responder_pkg.sv
// Shared types and helpers for the HD44780 bus responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hd44780_bus_responder_pkg;

    // Execution FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CLEAR = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

    // Decoded instruction class; the HD44780 selects by highest set bit
    typedef enum logic [3:0] {
        OPC_NOP   = 4'd0,
        OPC_CLEAR = 4'd1,
        OPC_HOME  = 4'd2,
        OPC_ENTRY = 4'd3,
        OPC_DISP  = 4'd4,
        OPC_SHIFT = 4'd5,
        OPC_FUNC  = 4'd6,
        OPC_CGRAM = 4'd7,
        OPC_DDRAM = 4'd8
    } opc_t;

    localparam int         LINE_LEN      = 40;
    localparam int         DDRAM_DEPTH   = 80;
    localparam logic [6:0] LINE2_BASE    = 7'h40;
    localparam logic [6:0] LINE1_LAST    = 7'h27;
    localparam logic [6:0] LINE2_LAST    = 7'h67;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;
    localparam logic [7:0] FILL_CHAR     = 8'h20;

    // Classify a command byte by its highest set bit
    function automatic opc_t decode_cmd(input logic [7:0] b);
        opc_t op;
        casez (b)
            8'b1???????: op = OPC_DDRAM;
            8'b01??????: op = OPC_CGRAM;
            8'b001?????: op = OPC_FUNC;
            8'b0001????: op = OPC_SHIFT;
            8'b00001???: op = OPC_DISP;
            8'b000001??: op = OPC_ENTRY;
            8'b0000001?: op = OPC_HOME;
            8'b00000001: op = OPC_CLEAR;
            default:     op = OPC_NOP;
        endcase
        return op;
    endfunction

    // Map a DDRAM address to {valid, linear index}; valid=0 for holes in the map
    function automatic logic [7:0] addr_to_idx(input logic [6:0] a, input logic two);
        logic [7:0] r;
        r = 8'h00;
        if (two) begin
            if (a <= LINE1_LAST)
                r = {1'b1, a};
            else if (a >= LINE2_BASE && a <= LINE2_LAST)
                r = {1'b1, a - LINE2_BASE + 7'(LINE_LEN)};
        end else if (a <= ONE_LINE_LAST) begin
            r = {1'b1, a};
        end
        return r;
    endfunction

    // Next DDRAM address after a cursor move; an unmapped address restarts at 7'h00
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc, input logic two);
        logic [7:0] m;
        logic [6:0] r;
        m = addr_to_idx(a, two);
        r = 7'h00;
        if (m[7]) begin
            if (two) begin
                if (inc)
                    r = (a == LINE1_LAST) ? LINE2_BASE : (a == LINE2_LAST) ? 7'h00 : a + 7'd1;
                else
                    r = (a == LINE2_BASE) ? LINE1_LAST : (a == 7'h00) ? LINE2_LAST : a - 7'd1;
            end else begin
                if (inc)
                    r = (a == ONE_LINE_LAST) ? 7'h00 : a + 7'd1;
                else
                    r = (a == 7'h00) ? ONE_LINE_LAST : a - 7'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hd44780_bus_responder_ddram.sv
// 80x8 simple dual-port display RAM: synchronous write, registered read.
// Latency: read data valid one clk after raddr; collision returns the old value.
// Backpressure: none; both ports accept every cycle, out-of-range reads return 8'h00.
module hd44780_bus_responder_ddram
    import hd44780_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [DDRAM_DEPTH];

    // Write port; addresses beyond the array are silently ignored
    always_ff @(posedge clk) begin
        if (we && waddr < 7'(DDRAM_DEPTH))
            mem[waddr] <= wdata;
    end

    // Read port; non-blocking update gives read-before-write on a same-index collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= 8'h00;
        else if (raddr < 7'(DDRAM_DEPTH))
            rdata <= mem[raddr];
        else
            rdata <= 8'h00;
    end

endmodule

// File: rtl/hd44780_bus_responder.sv
// Device side of the HD44780 4/8-bit LCD bus: nibble assembly, command decode, DDRAM mirror.
// Latency: strobe seen 3 clk after lcd_en falls; byte applied 1 clk later; rd_data 1 clk.
// Backpressure: none on the pins; bytes completing while busy are dropped and flagged.
module hd44780_bus_responder
    import hd44780_bus_responder_pkg::*;
#(
    parameter int CLK_HZ   = 27_000_000,
    parameter int EXEC_US  = 37,
    parameter int CLEAR_US = 1520
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [3:0] lcd_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_idx,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       four_bit,
    output logic       two_line,
    output logic       busy,
    output logic       timing_err,
    output logic       proto_err
);

    // Busy windows in clk cycles, counted from S_EXEC entry
    localparam logic [31:0] EXEC_CYC  = 32'((64'(CLK_HZ) * 64'(EXEC_US)) / 64'd1_000_000);
    localparam logic [31:0] CLEAR_CYC = 32'((64'(CLK_HZ) * 64'(CLEAR_US)) / 64'd1_000_000);
    // Power-up has no S_EXEC cycle, so the fill runs in front of the full clear window
    localparam logic [31:0] RESET_LIM = CLEAR_CYC + 32'(DDRAM_DEPTH) - 32'd1;

    // Pin synchronisers; en_sync[2] is the delayed copy used for edge detection
    logic [2:0] en_sync;
    logic [1:0] rs_sync;
    logic [1:0] rw_sync;
    logic [3:0] dat_s0;
    logic [3:0] dat_s1;
    logic       strobe;
    logic [7:0] byte_in;

    // Execution state
    state_t      state;
    logic [31:0] cnt;
    logic [31:0] lim;
    logic [6:0]  fill_idx;
    logic [6:0]  addr;
    logic        cg_mode;
    logic        id_inc;
    logic        phase_hi;
    logic [3:0]  hi_nib;
    logic [7:0]  cmd_byte;
    logic        cmd_rs;
    logic [7:0]  cur_map;

    // DDRAM write port
    logic       ram_we;
    logic [6:0] ram_waddr;
    logic [7:0] ram_wdata;

    // Bring the asynchronous host pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync <= 3'b000;
            rs_sync <= 2'b00;
            rw_sync <= 2'b00;
            dat_s0  <= 4'h0;
            dat_s1  <= 4'h0;
        end else begin
            en_sync <= {en_sync[1:0], lcd_en};
            rs_sync <= {rs_sync[0], lcd_rs};
            rw_sync <= {rw_sync[0], lcd_rw};
            dat_s0  <= lcd_data;
            dat_s1  <= dat_s0;
        end
    end

    assign strobe  = en_sync[2] & ~en_sync[1];
    // In 8-bit mode only DB7..DB4 are wired, so the low nibble reads as zero
    assign byte_in = four_bit ? {hi_nib, dat_s1} : {dat_s1, 4'h0};
    assign cur_map = addr_to_idx(addr, two_line);
    assign busy    = (state != S_IDLE);
    // 7'h7F marks a cursor parked on an unmapped address
    assign cursor_idx = cur_map[7] ? cur_map[6:0] : 7'h7F;

    // Select between the clear fill and a host data write
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fill_idx;
        ram_wdata = FILL_CHAR;
        if (state == S_CLEAR) begin
            ram_we = 1'b1;
        end else if (state == S_EXEC && cmd_rs && !cg_mode && cur_map[7]) begin
            ram_we    = 1'b1;
            ram_waddr = cur_map[6:0];
            ram_wdata = cmd_byte;
        end
    end

    // Nibble assembly, command execution and busy timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            cnt        <= 32'd0;
            lim        <= RESET_LIM;
            fill_idx   <= 7'd0;
            addr       <= 7'h00;
            cg_mode    <= 1'b0;
            id_inc     <= 1'b1;
            phase_hi   <= 1'b1;
            hi_nib     <= 4'h0;
            cmd_byte   <= 8'h00;
            cmd_rs     <= 1'b0;
            four_bit   <= 1'b0;
            two_line   <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            timing_err <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            // Host strobe: reads are unsupported, otherwise build up a byte
            if (strobe) begin
                if (rw_sync[1]) begin
                    proto_err <= 1'b1;
                end else if (four_bit && phase_hi) begin
                    hi_nib   <= dat_s1;
                    phase_hi <= 1'b0;
                end else begin
                    if (four_bit)
                        phase_hi <= 1'b1;
                    if (state == S_IDLE) begin
                        cmd_byte <= byte_in;
                        cmd_rs   <= rs_sync[1];
                        cnt      <= 32'd0;
                        state    <= S_EXEC;
                    end else begin
                        timing_err <= 1'b1;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                end
                S_EXEC: begin
                    cnt      <= cnt + 32'd1;
                    lim      <= EXEC_CYC - 32'd1;
                    fill_idx <= 7'd0;
                    state    <= S_BUSY;
                    if (cmd_rs) begin
                        // CGRAM is not modelled: data aimed there is discarded
                        if (!cg_mode) begin
                            if (!cur_map[7])
                                proto_err <= 1'b1;
                            addr <= step_addr(addr, id_inc, two_line);
                        end
                    end else begin
                        case (decode_cmd(cmd_byte))
                            OPC_DDRAM: begin
                                addr    <= cmd_byte[6:0];
                                cg_mode <= 1'b0;
                            end
                            OPC_CGRAM: cg_mode <= 1'b1;
                            OPC_FUNC: begin
                                two_line <= cmd_byte[3];
                                if (cmd_byte[4]) begin
                                    four_bit <= 1'b0;
                                    phase_hi <= 1'b1;
                                end else if (!four_bit) begin
                                    four_bit <= 1'b1;
                                    phase_hi <= 1'b1;
                                end
                            end
                            // Display shift is not modelled; only cursor moves take effect
                            OPC_SHIFT: begin
                                if (!cmd_byte[3])
                                    addr <= step_addr(addr, cmd_byte[2], two_line);
                            end
                            OPC_DISP: begin
                                disp_on   <= cmd_byte[2];
                                cursor_on <= cmd_byte[1];
                                blink_on  <= cmd_byte[0];
                            end
                            // The shift-on-write flag is accepted but has no visible effect
                            OPC_ENTRY: id_inc <= cmd_byte[1];
                            OPC_HOME: begin
                                addr    <= 7'h00;
                                cg_mode <= 1'b0;
                                lim     <= CLEAR_CYC - 32'd1;
                            end
                            OPC_CLEAR: begin
                                addr    <= 7'h00;
                                id_inc  <= 1'b1;
                                cg_mode <= 1'b0;
                                lim     <= CLEAR_CYC - 32'd1;
                                state   <= S_CLEAR;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_CLEAR: begin
                    cnt      <= cnt + 32'd1;
                    fill_idx <= fill_idx + 7'd1;
                    if (fill_idx == 7'(DDRAM_DEPTH - 1))
                        state <= S_BUSY;
                end
                S_BUSY: begin
                    cnt <= cnt + 32'd1;
                    if (cnt >= lim)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    hd44780_bus_responder_ddram u_ddram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
